// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order two-port writeback queue feeding a dual-write-port regfile
// Optional read bypass of pending entries: define REGFILE_WB_BYPASS_EN.
module regfile_wb_queue #(
    parameter int IDX_W  = 2,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in0_valid,
    output logic                       in0_ready,
    input  logic [IDX_W-1:0]           in0_idx,
    input  logic [DATA_W-1:0]          in0_data,
    input  logic                       in1_valid,
    output logic                       in1_ready,
    input  logic [IDX_W-1:0]           in1_idx,
    input  logic [DATA_W-1:0]          in1_data,
    output logic                       wp_0_en,
    output logic [IDX_W-1:0]           wp_0_idx,
    output logic [DATA_W-1:0]          wp_0_data,
    output logic                       wp_1_en,
    output logic [IDX_W-1:0]           wp_1_idx,
    output logic [DATA_W-1:0]          wp_1_data,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [IDX_W-1:0]           bp_idx,
    output logic                       bp_hit,
    output logic [DATA_W-1:0]          bp_data,
`endif
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [IDX_W-1:0]  idx_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [CW-1:0] free;
    logic [PW-1:0] head1, tail1;
    logic [1:0]    pop_n;
    logic          acc0, acc1;

    assign free      = DEPTH_C - count_q;
    assign in0_ready = (free >= CW'(1));
    assign in1_ready = (free >= CW'(2));
    assign count     = count_q;
    assign head1     = head_q + PW'(1);
    assign tail1     = tail_q + PW'(1);

    // Two same-idx writes never share a cycle, so the younger one waits for the next cycle.
    always_comb begin
        wp_0_en   = 1'b0;
        wp_0_idx  = '0;
        wp_0_data = '0;
        wp_1_en   = 1'b0;
        wp_1_idx  = '0;
        wp_1_data = '0;
        pop_n     = 2'd0;
        if (count_q != '0) begin
            wp_0_en   = 1'b1;
            wp_0_idx  = idx_q[head_q];
            wp_0_data = data_q[head_q];
            pop_n     = 2'd1;
            if ((count_q >= CW'(2)) && (idx_q[head1] != idx_q[head_q])) begin
                wp_1_en   = 1'b1;
                wp_1_idx  = idx_q[head1];
                wp_1_data = data_q[head1];
                pop_n     = 2'd2;
            end
        end
    end

    always_comb begin
        acc0   = in0_valid && in0_ready;
        acc1   = in1_valid && in1_ready;
        idx_d  = idx_q;
        data_d = data_q;
        if (acc0) begin
            idx_d[tail_q]  = in0_idx;
            data_d[tail_q] = in0_data;
        end
        if (acc1) begin
            idx_d[acc0 ? tail1 : tail_q]  = in1_idx;
            data_d[acc0 ? tail1 : tail_q] = in1_data;
        end
        tail_d  = tail_q + PW'(acc0) + PW'(acc1);
        head_d  = head_q + PW'(pop_n);
        count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= idx_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic [PW-1:0] bp_slot;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        bp_hit  = 1'b0;
        bp_data = '0;
        bp_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bp_slot = head_q + PW'(i);
            if ((CW'(i) < count_q) && (idx_q[bp_slot] == bp_idx)) begin
                bp_hit  = 1'b1;
                bp_data = data_q[bp_slot];
            end
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue with a regfile model
module tb_regfile_wb_queue;
    localparam int IDX_W  = 2;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in0_valid = 1'b0, in1_valid = 1'b0;
    logic in0_ready, in1_ready;
    logic [IDX_W-1:0] in0_idx = '0, in1_idx = '0;
    logic [DATA_W-1:0] in0_data = '0, in1_data = '0;
    logic wp_0_en, wp_1_en;
    logic [IDX_W-1:0] wp_0_idx, wp_1_idx;
    logic [DATA_W-1:0] wp_0_data, wp_1_data;
    logic [$clog2(DEPTH):0] count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [IDX_W-1:0] bp_idx = '0;
    logic bp_hit;
    logic [DATA_W-1:0] bp_data;
`endif

    int checks = 0;
    int passes = 0;
    ent_t sb[$];
    logic [DATA_W-1:0] reg_m  [1<<IDX_W];
    logic [DATA_W-1:0] prog_m [1<<IDX_W];

    always #5 clk = ~clk;

    regfile_wb_queue #(.IDX_W(IDX_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_idx(in0_idx), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_idx(in1_idx), .in1_data(in1_data),
        .wp_0_en(wp_0_en), .wp_0_idx(wp_0_idx), .wp_0_data(wp_0_data),
        .wp_1_en(wp_1_en), .wp_1_idx(wp_1_idx), .wp_1_data(wp_1_data),
`ifdef REGFILE_WB_BYPASS_EN
        .bp_idx(bp_idx), .bp_hit(bp_hit), .bp_data(bp_data),
`endif
        .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Checks the drain rule against the scoreboard and commits the model writes.
    task automatic check_ports();
        int n;
        logic e0, e1;
        n  = sb.size();
        e0 = (n >= 1);
        e1 = (n >= 2) && (sb[0].idx != sb[1].idx);
        chk("count", 32'(count), 32'(n));
        chk("in0_ready", 32'(in0_ready), 32'(DEPTH - n >= 1));
        chk("in1_ready", 32'(in1_ready), 32'(DEPTH - n >= 2));
        chk("wp_0_en", 32'(wp_0_en), 32'(e0));
        chk("wp_1_en", 32'(wp_1_en), 32'(e1));
`ifdef REGFILE_WB_BYPASS_EN
        begin
            logic h;
            logic [DATA_W-1:0] d;
            h = 1'b0;
            d = '0;
            for (int i = 0; i < n; i++)
                if (sb[i].idx == bp_idx) begin
                    h = 1'b1;
                    d = sb[i].data;
                end
            chk("bp_hit", 32'(bp_hit), 32'(h));
            chk("bp_data", 32'(bp_data), 32'(d));
        end
`endif
        if (wp_0_en && sb.size() > 0) begin
            chk("wp_0_entry", 32'({wp_0_idx, wp_0_data}), 32'(sb[0]));
            reg_m[wp_0_idx] = wp_0_data;
            void'(sb.pop_front());
        end else if (!wp_0_en) begin
            chk("wp_0_zero", 32'({wp_0_idx, wp_0_data}), 32'(0));
        end
        if (wp_1_en && sb.size() > 0) begin
            chk("wp_1_entry", 32'({wp_1_idx, wp_1_data}), 32'(sb[0]));
            reg_m[wp_1_idx] = wp_1_data;
            void'(sb.pop_front());
        end else if (!wp_1_en) begin
            chk("wp_1_zero", 32'({wp_1_idx, wp_1_data}), 32'(0));
        end
    endtask

    // One cycle: drive, check pre-edge state, record accepted requests, advance past the edge.
    task automatic cycle(input logic v0, input int i0, input int d0,
                         input logic v1, input int i1, input int d1);
        ent_t e;
        in0_valid = v0; in0_idx = IDX_W'(i0); in0_data = DATA_W'(d0);
        in1_valid = v1; in1_idx = IDX_W'(i1); in1_data = DATA_W'(d1);
`ifdef REGFILE_WB_BYPASS_EN
        bp_idx = IDX_W'($urandom_range(0, (1<<IDX_W)-1));
`endif
        #1;
        check_ports();
        if (v0 && in0_ready) begin
            e.idx = in0_idx; e.data = in0_data;
            sb.push_back(e);
            prog_m[e.idx] = e.data;
        end
        if (v1 && in1_ready) begin
            e.idx = in1_idx; e.data = in1_data;
            sb.push_back(e);
            prog_m[e.idx] = e.data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        for (int r = 0; r < (1<<IDX_W); r++) begin
            reg_m[r]  = '0;
            prog_m[r] = '0;
        end
        // Reset held with requests present
        in0_valid = 1'b1; in1_valid = 1'b1; in0_idx = 2'd1; in1_idx = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_wp_0_en", 32'(wp_0_en), 32'(0));
        chk("rst_wp_1_en", 32'(wp_1_en), 32'(0));
        in0_valid = 1'b0; in1_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write
        cycle(1'b1, 1, 5, 1'b0, 0, 0);
        chk("single_count", 32'(count), 32'(1));
        chk("single_wp0", 32'({wp_0_en, wp_0_idx, wp_0_data}), 32'({1'b1, 2'd1, 4'd5}));
        chk("single_wp1_en", 32'(wp_1_en), 32'(0));
        idle();
        chk("single_drained", 32'(count), 32'(0));

        // Dual distinct
        cycle(1'b1, 2, 3, 1'b1, 0, 9);
        chk("dual_wp0", 32'({wp_0_en, wp_0_idx, wp_0_data}), 32'({1'b1, 2'd2, 4'd3}));
        chk("dual_wp1", 32'({wp_1_en, wp_1_idx, wp_1_data}), 32'({1'b1, 2'd0, 4'd9}));
        idle();

        // Same idx splits across two cycles
        cycle(1'b1, 3, 4, 1'b1, 3, 7);
        chk("same_c1_wp0", 32'({wp_0_en, wp_0_idx, wp_0_data}), 32'({1'b1, 2'd3, 4'd4}));
        chk("same_c1_wp1_en", 32'(wp_1_en), 32'(0));
        idle();
        chk("same_c2_wp0", 32'({wp_0_en, wp_0_idx, wp_0_data}), 32'({1'b1, 2'd3, 4'd7}));
        idle();
        chk("same_reg3", 32'(reg_m[3]), 32'(7));

        // Same-idx traffic slows drain to one per cycle and pushes occupancy to 3
        cycle(1'b1, 1, 1, 1'b1, 1, 2);
        cycle(1'b1, 1, 3, 1'b1, 1, 4);
        chk("fill_count3", 32'(count), 32'(3));
        chk("fill_in0_ready", 32'(in0_ready), 32'(1));
        chk("fill_in1_ready", 32'(in1_ready), 32'(0));
        for (int k = 0; k < 12; k++) cycle(1'b1, 1, k, 1'b1, 2, k);
        repeat (5) idle();

        // Reset mid-operation drops pending entries
        cycle(1'b1, 0, 6, 1'b1, 1, 8);
        reset_n = 1'b0;
        #2;
        chk("midrst_count", 32'(count), 32'(0));
        chk("midrst_wp0_en", 32'(wp_0_en), 32'(0));
        sb.delete();
        for (int r = 0; r < (1<<IDX_W); r++) prog_m[r] = reg_m[r];
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) idle();

        // Random traffic: pointer wrap, order and final regfile state
        for (int k = 0; k < 400; k++)
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15));
        repeat (6) idle();
        for (int r = 0; r < (1<<IDX_W); r++)
            chk($sformatf("final_reg%0d", r), 32'(reg_m[r]), 32'(prog_m[r]));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
